// File: rtl/gf2m_digit_mul_if.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mul_if
//   Request/response bundle between a Montgomery-ladder control FSM and one
//   digit-serial GF(2^M) multiplier slot.
//
//   in_valid  master->slave  request strobe; a/b sampled with it
//   a, b      master->slave  operands, M bits each
//   out_valid slave->master  one-cycle result pulse
//   c         slave->master  product, held until the next out_valid
//   busy      slave->master  high while a product is being computed
//   error     slave->master  one-cycle pulse: a request arrived while busy
// ---------------------------------------------------------------------------
interface gf2m_digit_mul_if #(
  parameter int M = 163
) ();
  logic         in_valid;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic [M-1:0] c;
  logic         busy;
  logic         error;

  modport master (
    output in_valid, a, b,
    input  out_valid, c, busy, error
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, c, busy, error
  );
endinterface

// File: rtl/gf2m_digit_mul.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mul
//   Digit-serial GF(2^M) multiplier in polynomial basis: C = A*B mod F(x).
//   B is consumed D bits per cycle, most significant digit first; each bit
//   performs a shift-and-reduce of the accumulator followed by a conditional
//   XOR of A. A product takes NDIG = ceil(M/D) compute cycles, and the result
//   pulse follows NDIG+1 cycles after the request.
//
//   clk_i  clock, all state on the rising edge
//   rst_i  synchronous active-high reset; abandons any in-flight product
//   bus    slave side of gf2m_digit_mul_if (in_valid/a/b in,
//          out_valid/c/busy/error out)
// ---------------------------------------------------------------------------
module gf2m_digit_mul #(
  parameter int           M    = 163,
  parameter int           D    = 4,
  parameter logic [M-1:0] POLY = 'hC9   // F(x) without the x^M term
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gf2m_digit_mul_if.slave   bus
);

  localparam int NDIG = (M + D - 1) / D;
  localparam int NB   = NDIG * D;                      // padded width of B
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [M-1:0]  a_q;
  logic [NB-1:0] b_q;
  logic [M-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic [M-1:0]  c_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          error_q;

  // DONE is not busy, so a request there is taken back-to-back.
  logic accept;
  assign accept = bus.in_valid && (state_q != ST_CALC);

  // One digit of work: D shift-and-reduce steps, top bit of the digit first.
  // NOTE: blocking '=' inside always_comb chains the D steps within one cycle;
  // acc_d is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < D; j++) begin
      acc_d = {acc_d[M-2:0], 1'b0} ^ (acc_d[M-1] ? POLY : '0);
      if (b_q[NB-1-j]) begin
        acc_d = acc_d ^ a_q;
      end
    end
  end

  // Operand registers.
  // NOTE: these carry no reset; their contents only matter after a request
  // loads them, so resetting them would add logic for no behavioural gain.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= NB'(bus.b);          // zero padding lands in the leading digit
    end else if (state_q == ST_CALC) begin
      b_q <= b_q << D;
    end
  end

  // Control FSM with registered outputs.
  // NOTE: every sequential assignment uses '<=' so all registers update from
  // the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      error_q     <= bus.in_valid && busy_q;   // refused request, dropped
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.in_valid) begin
            acc_q   <= '0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            // Result is registered on the last digit so it is valid
            // for the whole DONE cycle.
            c_q         <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// ---------------------------------------------------------------------------
// tb_gf2m_digit_mul
//   Directed bench for gf2m_digit_mul (M=163, D=4, NIST B-163 polynomial).
//   Expected products come from hand-worked constants and an LSB-first
//   shift-and-add reference model.
// ---------------------------------------------------------------------------
module tb_gf2m_digit_mul;

  localparam int           M    = 163;
  localparam int           D    = 4;
  localparam logic [M-1:0] POLY = 'hC9;
  localparam int           LAT  = (M + D - 1) / D + 1;   // 42

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  gf2m_digit_mul_if #(.M(M)) bus ();

  gf2m_digit_mul #(.M(M), .D(D), .POLY(POLY)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [M-1:0] obs,
                       input logic [M-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // LSB-first reference: r += b[i] * (a * x^i mod F).
  function automatic logic [M-1:0] model_mul(input logic [M-1:0] a,
                                             input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_op();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[M-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for the result pulse.
  // lat counts rising edges from the request cycle to the out_valid cycle.
  task automatic run_mul(input logic [M-1:0] a, input logic [M-1:0] b,
                         output logic [M-1:0] c, output int lat,
                         output logic err_seen);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    lat          = 0;
    err_seen     = 1'b0;
    do begin
      tick();
      bus.in_valid = 1'b0;
      lat++;
      if (bus.error) err_seen = 1'b1;
    end while (!bus.out_valid && lat < 200);
    c = bus.c;
  endtask

  initial begin
    logic [M-1:0] a, b, c, ones, one;
    int           lat, n_ov;
    logic         err_seen;

    ones         = '1;
    one          = 1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", M'(bus.out_valid), '0);
    check("rst_c",         bus.c,             '0);
    check("rst_busy",      M'(bus.busy),      '0);
    check("rst_error",     M'(bus.error),     '0);

    // A=1 -> C=B, latency NDIG+1 from IDLE
    b = rand_op();
    run_mul(one, b, c, lat, err_seen);
    check("one_times_b", c, b);
    check("one_lat", M'(lat), M'(LAT));
    check("one_err", M'(err_seen), '0);

    // x^162 * x = x^163 = x^7+x^6+x^3+1
    run_mul(one << 162, one << 1, c, lat, err_seen);
    check("x163_reduce", c, 'hC9);
    // x^162 * x^2 = x^8+x^7+x^4+x
    run_mul(one << 162, one << 2, c, lat, err_seen);
    check("x164_reduce", c, 'h192);
    // 0 * all-ones
    run_mul('0, ones, c, lat, err_seen);
    check("zero_times_ones", c, '0);
    // (x+1)(x+1) = x^2+1
    run_mul('h3, 'h3, c, lat, err_seen);
    check("x1_squared", c, 'h5);

    // Back-to-back: request issued on the out_valid cycle
    a = rand_op();
    b = rand_op();
    run_mul(a, b, c, lat, err_seen);
    check("b2b_c",   c, model_mul(a, b));
    check("b2b_lat", M'(lat), M'(LAT));
    check("b2b_err", M'(err_seen), '0);

    // Random products against the reference model
    for (int i = 0; i < 1000; i++) begin
      a = rand_op();
      b = rand_op();
      run_mul(a, b, c, lat, err_seen);
      check("rand_c",   c, model_mul(a, b));
      check("rand_lat", M'(lat), M'(LAT));
    end

    // Second request 10 cycles into CALC: refused with one ERROR pulse
    a = rand_op();
    b = rand_op();
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    repeat (9) begin
      tick();
      lat++;
    end
    check("calc_busy", M'(bus.busy), M'(1));
    bus.a        = rand_op();
    bus.b        = rand_op();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat++;
    check("err_pulse", M'(bus.error), M'(1));
    tick();
    lat++;
    check("err_one_cycle", M'(bus.error), '0);
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("err_first_c",   bus.c, model_mul(a, b));
    check("err_first_lat", M'(lat), M'(LAT));
    n_ov = 0;
    repeat (60) begin
      tick();
      if (bus.out_valid) n_ov++;
    end
    check("err_no_extra_ov", M'(n_ov), '0);

    // Reset mid-CALC abandons the product
    bus.a        = rand_op();
    bus.b        = rand_op();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",      M'(bus.busy),      '0);
    check("midrst_c",         bus.c,             '0);
    check("midrst_out_valid", M'(bus.out_valid), '0);
    n_ov = 0;
    repeat (60) begin
      tick();
      if (bus.out_valid) n_ov++;
    end
    check("midrst_no_ov", M'(n_ov), '0);
    a = rand_op();
    b = rand_op();
    run_mul(a, b, c, lat, err_seen);
    check("post_rst_c",   c, model_mul(a, b));
    check("post_rst_lat", M'(lat), M'(LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
